// File: rtl/micro_sequencer_pkg.sv
// Shared types for the micro-sequencer: micro-instruction field layout and
// the decoded control word consumed by the ALU, memory unit and registers.
package micro_sequencer_pkg;

  localparam int UINSTR_W = 14;

  typedef enum logic [1:0] {
    KIND_ALU = 2'b00,
    KIND_MEM = 2'b01,
    KIND_REG = 2'b10,
    KIND_SYS = 2'b11
  } micro_kind_e;

  typedef enum logic { ST_RUN = 1'b0, ST_HALTED = 1'b1 } seq_state_e;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,  ALU_ADD = 4'd1,  ALU_SUB = 4'd2,  ALU_AND = 4'd3,
    ALU_OR  = 4'd4,  ALU_XOR = 4'd5,  ALU_NOT = 4'd6,  ALU_SHL = 4'd7,
    ALU_SHR = 4'd8,  ALU_INC = 4'd9,  ALU_DEC = 4'd10, ALU_CMP = 4'd11,
    ALU_PASS = 4'd12
  } alu_op_e;

  typedef enum logic [2:0] {
    MEM_NOP = 3'd0, MEM_READ = 3'd1, MEM_WRITE = 3'd2, MEM_FETCH = 3'd3,
    MEM_PUSH = 3'd4, MEM_POP = 3'd5, MEM_IO = 3'd6
  } memory_op_e;

  typedef enum logic [1:0] {
    REG_NOP = 2'd0, REG_LOAD = 2'd1, REG_ENABLE = 2'd2, REG_INC = 2'd3
  } reg_op_e;

  typedef struct packed {
    logic       reset;
    logic       halt;
    logic       control_unit_load;
    logic       next_instr;
    alu_op_e    alu_op;
    logic       alu_enable;
    memory_op_e memory_op;
    logic       bus_selector;
    logic       data_word_selector;
    reg_op_e    rax_op;
    reg_op_e    rbx_op;
    reg_op_e    rcx_op;
    reg_op_e    rdx_op;
  } control_word_t;

  localparam control_word_t CONTROL_WORD_ZERO = '0;

  localparam int KIND_LSB     = 12;
  localparam int LAST_BIT     = 0;
  // ALU fields
  localparam int ALU_OP_LSB   = 8;
  localparam int ALU_DST_LSB  = 6;
  localparam int ALU_DST_VLD  = 5;
  localparam int ALU_EN_BIT   = 4;
  localparam int ALU_OP_MAX   = 12;
  // MEM fields
  localparam int MEM_OP_LSB   = 9;
  localparam int MEM_BUS_BIT  = 8;
  localparam int MEM_DWS_BIT  = 7;
  localparam int MEM_REG_LSB  = 5;
  localparam int MEM_RGOP_LSB = 3;
  // REG fields
  localparam int REG_SRC_LSB  = 10;
  localparam int REG_SRC_VLD  = 9;
  localparam int REG_DST_LSB  = 7;
  localparam int REG_DST_VLD  = 6;
  // SYS fields
  localparam int SYS_RESET    = 11;
  localparam int SYS_HALT     = 10;
  localparam int SYS_LOAD     = 9;

endpackage

// File: rtl/micro_sequencer_decoder.sv
// Stateless decode of one 14-bit micro-instruction into a control word.
// next_instr is left zero here; it depends on sequencer state.
module micro_decoder
  import micro_sequencer_pkg::*;
(
  input  logic [UINSTR_W-1:0] uinstr,
  output control_word_t       control_word
);

  micro_kind_e kind;
  reg_op_e     ops [4];
  logic [1:0]  src, dst;

  assign kind = micro_kind_e'(uinstr[KIND_LSB +: 2]);
  assign src  = uinstr[REG_SRC_LSB +: 2];
  assign dst  = uinstr[REG_DST_LSB +: 2];

  always_comb begin
    control_word = CONTROL_WORD_ZERO;
    for (int i = 0; i < 4; i++) ops[i] = REG_NOP;
    unique case (kind)
      KIND_ALU: begin
        if (int'(uinstr[ALU_OP_LSB +: 4]) <= ALU_OP_MAX)
          control_word.alu_op = alu_op_e'(uinstr[ALU_OP_LSB +: 4]);
        control_word.alu_enable = uinstr[ALU_EN_BIT];
        if (uinstr[ALU_DST_VLD]) ops[uinstr[ALU_DST_LSB +: 2]] = REG_LOAD;
      end
      KIND_MEM: begin
        if (uinstr[MEM_OP_LSB +: 3] != 3'd7)
          control_word.memory_op = memory_op_e'(uinstr[MEM_OP_LSB +: 3]);
        control_word.bus_selector       = uinstr[MEM_BUS_BIT];
        control_word.data_word_selector = uinstr[MEM_DWS_BIT];
        ops[uinstr[MEM_REG_LSB +: 2]]   = reg_op_e'(uinstr[MEM_RGOP_LSB +: 2]);
      end
      KIND_REG: begin
        if (uinstr[REG_SRC_VLD]) ops[src] = REG_ENABLE;
        // A register both driving and loading itself is a no-op.
        if (uinstr[REG_DST_VLD])
          ops[dst] = (uinstr[REG_SRC_VLD] && src == dst) ? REG_NOP : REG_LOAD;
      end
      KIND_SYS: begin
        control_word.reset             = uinstr[SYS_RESET];
        control_word.halt              = uinstr[SYS_HALT] & ~uinstr[SYS_RESET];
        control_word.control_unit_load = uinstr[SYS_LOAD] & ~uinstr[SYS_RESET];
      end
    endcase
    control_word.rax_op = ops[0];
    control_word.rbx_op = ops[1];
    control_word.rcx_op = ops[2];
    control_word.rdx_op = ops[3];
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: walks {opcode, step} through the external ROM and
// registers the decoded word of the address presented in the previous cycle.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5,
  parameter int STEP_WIDTH   = 4,
  parameter int FETCH_OPCODE = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall_i,
  input  logic                               resume_i,
  input  logic [OPCODE_WIDTH-1:0]            opcode_i,
  input  logic [UINSTR_W-1:0]                uinstr_i,
  output logic [OPCODE_WIDTH+STEP_WIDTH-1:0] uaddr_o,
  output control_word_t                      control_word_o,
  output logic                               halted_o,
  output logic                               seq_error_o
);

  localparam logic [OPCODE_WIDTH-1:0] FETCH = OPCODE_WIDTH'(FETCH_OPCODE);

  seq_state_e              state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  control_word_t           dec_cw, cw_q, cw_d;
  logic                    err_q, err_d;
  logic                    last;

  micro_decoder u_dec (.uinstr(uinstr_i), .control_word(dec_cw));

  assign last = uinstr_i[LAST_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      opcode_q <= FETCH;
      step_q   <= '0;
      cw_q     <= CONTROL_WORD_ZERO;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      step_q   <= step_d;
      cw_q     <= cw_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    step_d   = step_q;
    cw_d     = cw_q;
    err_d    = err_q;
    case (state_q)
      ST_RUN: if (!stall_i) begin
        cw_d            = dec_cw;
        cw_d.next_instr = last && (opcode_q != FETCH);
        // Redirects in priority order: soft reset, opcode load, end of routine.
        if (dec_cw.reset) begin
          opcode_d = FETCH;
          step_d   = '0;
        end else if (dec_cw.control_unit_load) begin
          opcode_d = opcode_i;
          step_d   = '0;
        end else if (last) begin
          opcode_d = FETCH;
          step_d   = '0;
        end else if (step_q == '1) begin
          opcode_d = FETCH;
          step_d   = '0;
          err_d    = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
        if (dec_cw.halt) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        cw_d = CONTROL_WORD_ZERO;
        if (resume_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign uaddr_o        = {opcode_q, step_q};
  assign control_word_o = cw_q;
  assign halted_o       = (state_q == ST_HALTED);
  assign seq_error_o    = err_q;

endmodule
